// File: rtl/sbox_lane_pipe.sv
// Multi-lane AES S-box / inverse S-box, three register stages with a
// single global stall. Each lane substitutes one byte per beat; the mode
// and sideband tag ride along with the data.
module sbox_lane_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_inv
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [2047:0] build_fwd();
    logic [2047:0] t;
    t = '0;
    for (int unsigned i = 0; i < 256; i++)
      t[8*i +: 8] = affine(gf_inv(i[7:0]));
    return t;
  endfunction

  function automatic logic [2047:0] build_inv(input logic [2047:0] f);
    logic [2047:0] t;
    t = '0;
    for (int unsigned i = 0; i < 256; i++)
      t[{f[8*i +: 8], 3'b000} +: 8] = i[7:0];
    return t;
  endfunction

  // Byte x of each table lives at bits [8x+7:8x].
  localparam logic [2047:0] SBOX_FWD = build_fwd();
  localparam logic [2047:0] SBOX_INV = build_inv(SBOX_FWD);

  logic advance;

  // Stage 1: eight candidate rows per table, indexed by x[7:5].
  logic [LANES-1:0][7:0][7:0] row_f_nxt;
  logic [LANES-1:0][7:0][7:0] row_i_nxt;
  logic [LANES-1:0][7:0][7:0] s1_row_f;
  logic [LANES-1:0][7:0][7:0] s1_row_i;
  logic [LANES-1:0][2:0]      s1_sel;
  logic                       s1_valid;
  logic                       s1_mode;
  logic [TAG_W-1:0]           s1_tag;

  // Stage 2: two candidates per lane, indexed by x[7].
  logic [LANES-1:0][1:0][7:0] cand_nxt;
  logic [LANES-1:0][1:0][7:0] s2_cand;
  logic [LANES-1:0]           s2_hi;
  logic                       s2_valid;
  logic                       s2_mode;
  logic [TAG_W-1:0]           s2_tag;

  logic [8*LANES-1:0]         out_nxt;

  // Global stall: everything moves only when the output slot can drain.
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance;
  end

  // 32:1 lookup on x[4:0] for every row of both tables.
  always_comb begin
    row_f_nxt = '0;
    row_i_nxt = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned r = 0; r < 8; r++) begin
        row_f_nxt[l][r] = SBOX_FWD[{r[2:0], in_data[8*l +: 5], 3'b000} +: 8];
        row_i_nxt[l][r] = SBOX_INV[{r[2:0], in_data[8*l +: 5], 3'b000} +: 8];
      end
    end
  end

  // Stage 1 register; payload loads only for real beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_tag   <= '0;
      s1_row_f <= '0;
      s1_row_i <= '0;
      s1_sel   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode  <= in_inv;
        s1_tag   <= in_tag;
        s1_row_f <= row_f_nxt;
        s1_row_i <= row_i_nxt;
        for (int unsigned l = 0; l < LANES; l++)
          s1_sel[l] <= in_data[8*l+5 +: 3];
      end
    end
  end

  // 4:1 select on x[6:5] plus table choice by mode.
  always_comb begin
    cand_nxt = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned h = 0; h < 2; h++) begin
        cand_nxt[l][h] = s1_mode ? s1_row_i[l][{h[0], s1_sel[l][1:0]}]
                                 : s1_row_f[l][{h[0], s1_sel[l][1:0]}];
      end
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_tag   <= '0;
      s2_cand  <= '0;
      s2_hi    <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode <= s1_mode;
        s2_tag  <= s1_tag;
        s2_cand <= cand_nxt;
        for (int unsigned l = 0; l < LANES; l++)
          s2_hi[l] <= s1_sel[l][2];
      end
    end
  end

  // Final 2:1 select on x[7].
  always_comb begin
    out_nxt = '0;
    for (int unsigned l = 0; l < LANES; l++)
      out_nxt[8*l +: 8] = s2_cand[l][s2_hi[l]];
  end

  // Output register; holds last beat through bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_inv   <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= out_nxt;
        out_tag  <= s2_tag;
        out_inv  <= s2_mode;
      end
    end
  end

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Bench for sbox_lane_pipe: three instances (4/4, 1/1, 16/1 lanes/tag bits)
// share one stimulus stream and are checked against an occupancy-queue model
// and S-box tables derived independently from GF(2^8) arithmetic.
module tb_sbox_lane_pipe;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_inv;
  logic [127:0] in_data;
  logic [3:0]   in_tag;
  logic         out_ready;

  logic         rdy4, rdy1, rdy16;
  logic         ov4, ov1, ov16;
  logic [31:0]  od4;
  logic [7:0]   od1;
  logic [127:0] od16;
  logic [3:0]   ot4;
  logic [0:0]   ot1, ot16;
  logic         oi4, oi1, oi16;

  sbox_lane_pipe #(.LANES(4), .TAG_W(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_inv(in_inv), .in_data(in_data[31:0]), .in_tag(in_tag),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_tag(ot4),
    .out_inv(oi4));

  sbox_lane_pipe #(.LANES(1), .TAG_W(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_inv(in_inv), .in_data(in_data[7:0]), .in_tag(in_tag[0:0]),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_tag(ot1),
    .out_inv(oi1));

  sbox_lane_pipe #(.LANES(16), .TAG_W(1)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .in_inv(in_inv), .in_data(in_data), .in_tag(in_tag[0:0]),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .out_tag(ot16),
    .out_inv(oi16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference S-box tables ----------------
  logic [7:0] ref_s  [256];
  logic [7:0] ref_si [256];

  // Carry-less product then reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ginv_search(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] y;
    r = 8'h00;
    for (int k = 1; k < 256; k++) begin
      y = 8'(k);
      if (x != 8'h00 && gmul(x, y) == 8'h01) r = y;
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_matrix(input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int l = 0; l < 16; l++)
      r[8*l +: 8] = inv ? ref_si[d[8*l +: 8]] : ref_s[d[8*l +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- in-flight model ----------------
  // Each accepted beat counts the stall-free cycles it has spent inside;
  // the head is visible once it has been through three advances.
  typedef struct {
    logic [127:0] exp;
    logic [3:0]   tag;
    logic         inv;
    int           age;
  } beat_t;
  beat_t fly[$];

  logic [127:0] cap[$];
  bit           capture_en = 1'b0;

  // Drive one cycle (called at posedge+1), check at negedge, update model.
  task automatic run_cycle(input logic v, input logic [127:0] d, input logic inv,
                           input logic [3:0] tag, input logic [127:0] exp_d,
                           input logic ordy, output logic acc);
    logic  exp_ov;
    logic  exp_rdy;
    beat_t nb;
    in_valid  = v;
    in_data   = d;
    in_inv    = inv;
    in_tag    = tag;
    out_ready = ordy;
    @(negedge clk);
    exp_ov  = (fly.size() > 0) && (fly[0].age == 3);
    exp_rdy = !exp_ov || ordy;
    chk("out_valid", {ov16, ov1, ov4}, {3{exp_ov}});
    chk("in_ready", {rdy16, rdy1, rdy4}, {3{exp_rdy}});
    if (exp_ov) begin
      chk("data_l4", od4, fly[0].exp[31:0]);
      chk("data_l1", od1, fly[0].exp[7:0]);
      chk("data_l16", od16, fly[0].exp);
      chk("tag", {ot16, ot1, ot4}, {fly[0].tag[0], fly[0].tag[0], fly[0].tag});
      chk("out_inv", {oi16, oi1, oi4}, {3{fly[0].inv}});
      if (capture_en && ordy) cap.push_back(od16);
    end
    @(posedge clk);
    acc = v && exp_rdy;
    if (exp_rdy) begin
      if (exp_ov) void'(fly.pop_front());
      for (int k = 0; k < fly.size(); k++) fly[k].age = fly[k].age + 1;
      if (v) begin
        nb.exp = exp_d;
        nb.tag = tag;
        nb.inv = inv;
        nb.age = 1;
        fly.push_back(nb);
      end
    end
    #1;
  endtask

  task automatic idle();
    logic acc;
    run_cycle(1'b0, rand128(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              '0, 1'b1, acc);
  endtask

  logic [127:0] src_d   [256];
  logic [127:0] src_exp [256];
  logic         src_inv [256];
  logic [3:0]   src_tag [256];
  logic [127:0] orig    [256];

  // Push n source beats with random gaps (pv%) and random out_ready (pr%).
  task automatic stream(input int n, input int pv, input int pr);
    int   i;
    int   guard;
    logic acc;
    logic v;
    logic r;
    i = 0;
    guard = 0;
    while (i < n && guard < 40 * n + 100) begin
      v = ($urandom_range(0, 99) < pv);
      r = ($urandom_range(0, 99) < pr);
      if (v) run_cycle(1'b1, src_d[i], src_inv[i], src_tag[i], src_exp[i], r, acc);
      else   run_cycle(1'b0, rand128(), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), '0, r, acc);
      if (acc) i++;
      guard++;
    end
    repeat (4) idle();
  endtask

  typedef struct {
    logic        inv;
    logic [31:0] din;
    logic [3:0]  tag;
    logic [31:0] dexp;
  } vec_t;
  vec_t tbl [6];

  initial begin
    logic         acc;
    logic [127:0] d;
    logic         iv;
    logic [7:0]   b;

    tbl[0] = '{1'b0, 32'hFF530100, 4'h5, 32'h16ED7C63};
    tbl[1] = '{1'b1, 32'hFFED6300, 4'hA, 32'h7D530052};
    tbl[2] = '{1'b0, 32'h8F1F4010, 4'h3, 32'h73C009CA};
    tbl[3] = '{1'b0, 32'hF0208000, 4'hC, 32'h8CB7CD63};
    tbl[4] = '{1'b1, 32'h0109CA7C, 4'h6, 32'h09401001};
    tbl[5] = '{1'b1, 32'h16CD7309, 4'hF, 32'hFF808F40};

    for (int x = 0; x < 256; x++)
      ref_s[x] = aff_matrix(ginv_search(8'(x)));
    for (int s = 0; s < 256; s++) begin
      b = 8'(s);
      ref_si[s] = ginv_search(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    end

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    // Reset state, with downstream not ready.
    #3;
    chk("reset_valid", {ov16, ov1, ov4}, '0);
    chk("reset_ready", {rdy16, rdy1, rdy4}, 3'b111);
    chk("reset_data", {od16, od4, od1}, '0);
    chk("reset_tag_inv", {ot16, ot1, ot4, oi16, oi1, oi4}, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-answer table, each beat isolated so the single-cycle pulse shows.
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, {4{tbl[i].din}}, tbl[i].inv, tbl[i].tag, {4{tbl[i].dexp}},
                1'b1, acc);
      repeat (4) idle();
    end

    // Backpressure: 10 beats, tags 0..9 for order checking.
    for (int i = 0; i < 10; i++) begin
      src_d[i]   = rand128();
      src_inv[i] = 1'($urandom_range(0, 1));
      src_tag[i] = 4'(i);
      src_exp[i] = ref_beat(src_d[i], src_inv[i]);
    end
    stream(10, 100, 50);

    // Round trip: every byte value on every lane forward, then fed back inverted.
    for (int i = 0; i < 256; i++) begin
      for (int l = 0; l < 16; l++) orig[i][8*l +: 8] = 8'(i + l);
      src_d[i]   = orig[i];
      src_inv[i] = 1'b0;
      src_tag[i] = 4'(i);
      src_exp[i] = ref_beat(orig[i], 1'b0);
    end
    cap.delete();
    capture_en = 1'b1;
    stream(256, 100, 100);
    capture_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      src_d[i]   = (i < cap.size()) ? cap[i] : '0;
      src_inv[i] = 1'b1;
      src_exp[i] = orig[i];
    end
    stream(256, 100, 100);

    // Alternating mode every beat with gaps and stalls.
    for (int i = 0; i < 64; i++) begin
      src_d[i]   = rand128();
      src_inv[i] = 1'(i % 2);
      src_tag[i] = 4'($urandom_range(0, 15));
      src_exp[i] = ref_beat(src_d[i], src_inv[i]);
    end
    stream(64, 80, 70);

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      d  = rand128();
      iv = 1'($urandom_range(0, 1));
      run_cycle(1'b1, d, iv, 4'(k), ref_beat(d, iv), 1'b1, acc);
    end
    chk("pre_reset_valid", {ov16, ov1, ov4}, 3'b111);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {ov16, ov1, ov4}, '0);
    chk("midrst_ready", {rdy16, rdy1, rdy4}, 3'b111);
    chk("midrst_data", {od16, od4, od1}, '0);
    chk("midrst_tag_inv", {ot16, ot1, ot4, oi16, oi1, oi4}, '0);
    fly.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) idle();
    d = rand128();
    run_cycle(1'b1, d, 1'b0, 4'h9, ref_beat(d, 1'b0), 1'b1, acc);
    repeat (4) idle();

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      src_d[i]   = rand128();
      src_inv[i] = 1'($urandom_range(0, 1));
      src_tag[i] = 4'($urandom_range(0, 15));
      src_exp[i] = ref_beat(src_d[i], src_inv[i]);
    end
    stream(200, 60, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
